// File: rtl/jt51_slot_dly_if.sv
// Bus bundle for jt51_slot_dly: control/data inputs and the delayed-data outputs.
// Optional parity error flag present when JT51_SLOT_DLY_PARITY_EN is defined.
interface jt51_slot_dly_if #(
    parameter int WIDTH = 5,
    parameter int AW    = 5
);
    logic             cen;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    dly;
    logic             hold;
    logic             clr;
    logic [WIDTH-1:0] drop;
    logic [AW-1:0]    slot;
    logic             busy;
`ifdef JT51_SLOT_DLY_PARITY_EN
    logic             perr;
`endif

    modport master (
        output cen, din, dly, hold, clr,
`ifdef JT51_SLOT_DLY_PARITY_EN
        input  perr,
`endif
        input  drop, slot, busy
    );

    modport slave (
        input  cen, din, dly, hold, clr,
`ifdef JT51_SLOT_DLY_PARITY_EN
        output perr,
`endif
        output drop, slot, busy
    );
endinterface

// File: rtl/jt51_slot_dly.sv
// RAM-backed per-slot delay line with runtime length, hold/recirculate and a clearing sweep.
// Optional even-parity protection per entry: define JT51_SLOT_DLY_PARITY_EN.
module jt51_slot_dly #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 32,
    parameter int AW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    jt51_slot_dly_if.slave bus
);
    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST     = AW'(STAGES - 1);

    logic [0:0]       r_state;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    r_len;
    logic [WIDTH-1:0] r_drop;
    logic             r_busy;
    logic [WIDTH-1:0] r_mem [STAGES];

    logic [AW-1:0]    w_dly_sat;
    logic [WIDTH-1:0] w_rd;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;

`ifdef JT51_SLOT_DLY_PARITY_EN
    logic             r_par [STAGES];
    logic             r_perr;
    logic             w_rd_par;
    logic             w_wpar;
`endif

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_dly_sat = (bus.dly > LAST) ? LAST : bus.dly;
        w_rd      = r_mem[r_ptr];
        w_we      = 1'b0;
        w_waddr   = r_ptr;
        w_wdata   = bus.din;
        if (bus.cen && !bus.clr) begin
            if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = '0;
            end else if (!bus.hold) begin
                w_we = 1'b1;
            end
        end
    end

`ifdef JT51_SLOT_DLY_PARITY_EN
    always_comb begin
        w_rd_par = r_par[r_ptr];
        w_wpar   = (r_state == ST_CLEAR) ? 1'b0 : ^bus.din;
    end
`endif

    // NOTE: the storage array has no reset; the CLEAR sweep initialises it so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
`ifdef JT51_SLOT_DLY_PARITY_EN
            r_par[w_waddr] <= w_wpar;
`endif
        end
    end

    // Read-before-write: drop captures the old entry on the same edge the new one is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_len   <= LAST;
            r_drop  <= '0;
            r_busy  <= 1'b1;
        end else if (bus.clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_drop  <= '0;
            r_busy  <= 1'b1;
        end else if (bus.cen) begin
            if (r_state == ST_CLEAR) begin
                r_drop <= '0;
                if (r_cnt == LAST) begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_ptr   <= '0;
                    r_len   <= w_dly_sat;
                    r_busy  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + AW'(1);
                end
            end else begin
                r_drop <= w_rd;
                // Length changes only take effect at the wrap, never mid-pass.
                if (r_ptr == r_len) begin
                    r_ptr <= '0;
                    r_len <= w_dly_sat;
                end else begin
                    r_ptr <= r_ptr + AW'(1);
                end
            end
        end
    end

`ifdef JT51_SLOT_DLY_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else if (bus.clr) begin
            r_perr <= 1'b0;
        end else if (bus.cen) begin
            r_perr <= (r_state == ST_RUN) && ((^w_rd) != w_rd_par);
        end
    end

    assign bus.perr = r_perr;
`endif

    assign bus.drop = r_drop;
    assign bus.slot = r_ptr;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_jt51_slot_dly.sv
// Self-checking bench for jt51_slot_dly: directed scenarios plus randomized traffic
// against a slot-array reference model.
module tb_jt51_slot_dly;
    localparam int WIDTH  = 5;
    localparam int STAGES = 32;
    localparam int AW     = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    jt51_slot_dly_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    jt51_slot_dly #(.WIDTH(WIDTH), .STAGES(STAGES), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents per slot, read pointer, latched length, remaining sweep edges.
    int m_mem [STAGES];
    bit m_bad [STAGES];
    int m_ptr, m_len, m_clear, m_drop, m_busy, m_perr;

    function automatic int sat(input int d);
        return (d > STAGES - 1) ? STAGES - 1 : d;
    endfunction

    function automatic void model_reset();
        m_clear = STAGES;
        m_busy  = 1;
        m_ptr   = 0;
        m_len   = STAGES - 1;
        m_drop  = 0;
        m_perr  = 0;
    endfunction

    function automatic void model_edge();
        if (bus.clr) begin
            m_clear = STAGES;
            m_busy  = 1;
            m_ptr   = 0;
            m_drop  = 0;
            m_perr  = 0;
        end else if (bus.cen) begin
            if (m_clear > 0) begin
                m_mem[STAGES - m_clear] = 0;
                m_bad[STAGES - m_clear] = 0;
                m_clear = m_clear - 1;
                m_drop  = 0;
                m_perr  = 0;
                if (m_clear == 0) begin
                    m_busy = 0;
                    m_ptr  = 0;
                    m_len  = sat(int'(bus.dly));
                end
            end else begin
                m_drop = m_mem[m_ptr];
                m_perr = m_bad[m_ptr] ? 1 : 0;
                if (!bus.hold) begin
                    m_mem[m_ptr] = int'(bus.din);
                    m_bad[m_ptr] = 0;
                end
                if (m_ptr == m_len) begin
                    m_ptr = 0;
                    m_len = sat(int'(bus.dly));
                end else begin
                    m_ptr = m_ptr + 1;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: sample away from the edge, advance the model, compare all outputs.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        chk({tag, "_drop"}, 32'(bus.drop), 32'(m_drop));
        chk({tag, "_slot"}, 32'(bus.slot), 32'(m_ptr));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(m_busy));
`ifdef JT51_SLOT_DLY_PARITY_EN
        chk({tag, "_perr"}, 32'(bus.perr), 32'(m_perr));
`endif
    endtask

    task automatic run_to_slot(input int s, input string tag);
        for (int n = 0; n < 64 && (m_ptr != s || m_busy != 0); n++) begin
            bus.din = WIDTH'($urandom);
            step(tag);
        end
        chk({tag, "_reach"}, 32'(bus.slot), 32'(s));
    endtask

    initial begin
        int j;
        bus.cen  = 1'b0;
        bus.din  = '0;
        bus.dly  = AW'(31);
        bus.hold = 1'b0;
        bus.clr  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_drop", 32'(bus.drop), 32'd0);
        chk("rst_slot", 32'(bus.slot), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.cen = 1'b1;
        rst_n   = 1'b1;

        // 1: sweep lasts 32 cen edges, then a full pass of zeros
        for (int i = 0; i < STAGES; i++) begin
            bus.din = WIDTH'($urandom);
            step("s1_sweep");
            chk("s1_busy_len", 32'(bus.busy), (i < STAGES - 1) ? 32'd1 : 32'd0);
        end
        chk("s1_slot0", 32'(bus.slot), 32'd0);
        for (int i = 1; i <= STAGES; i++) begin
            bus.din = WIDTH'($urandom);
            if (i == 17) bus.dly = AW'(4);
            step("s1_pass");
            chk("s1_zero", 32'(bus.drop), 32'd0);
            chk("s1_slotseq", 32'(bus.slot), 32'(i % STAGES));
        end

        // 2: L=5 latency, din=1..15
        for (int k = 1; k <= 15; k++) begin
            bus.din = WIDTH'(k);
            step("s2");
            if (k >= 6) chk("s2_lat", 32'(bus.drop), 32'(k - 5));
            chk("s2_slotseq", 32'(bus.slot), 32'(k % 5));
        end

        // 3: cen toggling, only cen edges count
        j = 0;
        for (int e = 0; e < 20; e++) begin
            bus.cen = (e % 2 == 0);
            if (bus.cen) begin
                j++;
                bus.din = WIDTH'(15 + j);
            end else begin
                bus.din = 5'h1F;
            end
            step("s3");
            chk("s3_lat", 32'(bus.drop), 32'(10 + j));
        end
        bus.cen = 1'b1;

        // 4: fill 5..9 then two held passes
        run_to_slot(0, "s4_align");
        for (int k = 5; k <= 9; k++) begin
            bus.din = WIDTH'(k);
            step("s4_fill");
        end
        bus.hold = 1'b1;
        bus.din  = 5'h1F;
        for (int i = 0; i < 10; i++) begin
            step("s4_hold");
            chk("s4_rep", 32'(bus.drop), 32'(5 + (i % 5)));
        end
        bus.hold = 1'b0;

        // 5: dly 4->2 at slot 2 applies only after the wrap
        run_to_slot(2, "s5_align");
        bus.dly = AW'(2);
        begin
            int exp_slot [6] = '{3, 4, 0, 1, 2, 0};
            for (int i = 0; i < 6; i++) begin
                bus.din = WIDTH'($urandom);
                step("s5");
                chk("s5_slotseq", 32'(bus.slot), 32'(exp_slot[i]));
            end
        end

        // L=1 boundary: each edge returns the previous din
        bus.dly = AW'(0);
        for (int n = 0; n < 8 && !(m_len == 0 && m_ptr == 0); n++) begin
            bus.din = WIDTH'($urandom);
            step("l1_align");
        end
        for (int i = 0; i < 6; i++) begin
            bus.din = WIDTH'(i + 3);
            step("l1");
            if (i > 0) chk("l1_prev", 32'(bus.drop), 32'(i + 2));
            chk("l1_slot", 32'(bus.slot), 32'd0);
        end

        // Randomized traffic: cen gaps, hold, dly changes, rare clr
        for (int i = 0; i < 400; i++) begin
            bus.cen  = ($urandom_range(0, 3) != 0);
            bus.hold = ($urandom_range(0, 7) == 0);
            bus.clr  = ($urandom_range(0, 149) == 0);
            bus.din  = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) bus.dly = AW'($urandom_range(0, STAGES - 1));
            step("rnd");
        end
        bus.cen  = 1'b1;
        bus.hold = 1'b0;
        bus.clr  = 1'b0;

        // 6: clr at slot 3 with non-zero data
        bus.dly = AW'(4);
        for (int n = 0; n < 100 && !(m_busy == 0 && m_len == 4); n++) begin
            bus.din = WIDTH'($urandom) | WIDTH'(1);
            step("s6_prep");
        end
        for (int n = 0; n < 10 && m_ptr != 3; n++) begin
            bus.din = WIDTH'($urandom) | WIDTH'(1);
            step("s6_prep");
        end
        chk("s6_at3", 32'(bus.slot), 32'd3);
        bus.clr = 1'b1;
        step("s6_clr");
        chk("s6_busy_on", 32'(bus.busy), 32'd1);
        bus.clr = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            bus.din = WIDTH'($urandom) | WIDTH'(1);
            step("s6_sweep");
            chk("s6_busy_len", 32'(bus.busy), (i < STAGES - 1) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            bus.din = WIDTH'($urandom) | WIDTH'(1);
            step("s6_run");
            if (i < 5) chk("s6_zero", 32'(bus.drop), 32'd0);
            chk("s6_slotseq", 32'(bus.slot), 32'((i + 1) % 5));
        end

`ifdef JT51_SLOT_DLY_PARITY_EN
        // Flip one stored bit; perr fires only on the edge reading that entry
        bus.hold = 1'b1;
        dut.r_mem[2][0] = ~dut.r_mem[2][0];
        m_mem[2] = m_mem[2] ^ 1;
        m_bad[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("par");
            chk("par_pulse", 32'(bus.perr), (i == 2) ? 32'd1 : 32'd0);
        end
        bus.hold = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt51_slot_dly.md
Name: jt51_slot_dly

Overview:
- RAM-backed, runtime-programmable delay line for per-slot operator/channel state in the JT51 pipeline.
- Generalises the fixed flip-flop shifter:
  - the depth is selectable at run time;
  - a hold (recirculate) mode freezes contents;
  - a self-clearing sweep runs after reset or on request.
- Sits between pipeline stages that must realign data by a number of slots that is set per configuration.

Parameters:
- WIDTH, 5: data bits per entry.
- STAGES, 32: maximum number of entries, which is the maximum delay.
- AW, 5: pointer and dly width; must satisfy 2^AW >= STAGES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  clock enable; all state advances only on clk edges with cen=1.
- din  in  WIDTH  data written at the current slot.
- dly  in  AW  delay select; effective length L = dly+1, legal 0..STAGES-1.
- hold  in  1  1 = recirculate the stored entry and ignore din.
- clr  in  1  1-cycle request to zero all entries.
- drop  out  WIDTH  delayed data, registered.
- slot  out  AW  current write/read pointer.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - drop=0, slot=0, busy=1;
  - len_r=STAGES-1;
  - state=CLEAR, sweep counter=0;
  - memory contents are undefined until the sweep completes.
- States: CLEAR, RUN.
- CLEAR, per cen edge:
  - mem[cnt] <= 0; cnt++;
  - drop is held at 0 and busy=1.
- CLEAR exit, after entry STAGES-1 is written:
  - next state RUN;
  - ptr=0, len_r<=dly, busy<=0.
  - The sweep always covers all STAGES entries, whatever dly is.
- RUN, per cen edge, read-before-write at ptr:
  - drop <= mem[ptr];
  - mem[ptr] <= hold ? mem[ptr] : din;
  - ptr <= (ptr==len_r) ? 0 : ptr+1.
- Latency: din sampled at cen edge k appears on drop immediately after cen edge k+L. Only cen edges are counted.
- dly changes are latched into len_r only on the wrap edge (ptr==len_r) or at CLEAR exit. A mid-pass change never truncates the current pass.
- When L shrinks, entries above the new len_r are no longer read.
- When L grows, entries len_r+1..new len_r still hold stale data from earlier use. They are not guaranteed zero unless clr is issued.
- dly > STAGES-1 is illegal. The RTL saturates it to STAGES-1.
- hold=1: drop still updates from memory and ptr still advances. The contents are preserved exactly, so one full pass with hold=1 reproduces the same drop sequence.
- clr=1, sampled on any clk edge regardless of cen:
  - enters CLEAR with cnt=0;
  - busy goes to 1 on the following cycle.
  - clr asserted during CLEAR restarts the sweep from cnt=0.
- clr and hold asserted together: clr wins.
- cen=0: no state change; drop, slot and busy hold.
- slot equals ptr in RUN and 0 in CLEAR.
- L=1 (dly=0): ptr stays 0. Each cen edge reads the previous din and writes the new one, giving a 1-slot delay.

Optional Feature:
- Macro: JT51_SLOT_DLY_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit computed from din on write; recirculated entries keep their stored parity;
  - CLEAR writes parity 0;
  - an extra output perr (1 bit) pulses high for one cen step when the parity of the read entry mismatches;
  - perr resets to 0 and is forced 0 in CLEAR.
- When undefined: no parity storage and no perr port.

Test Plan:
1. Release rst_n with cen=1 and dly=31. Required: busy=1 for exactly 32 cen edges, then busy=0, slot=0, and drop=0 for the next 32 edges.
2. dly=4 (L=5), drive din=1,2,3,… on consecutive cen edges from slot 0. Required: drop=1 right after the 5th following edge, then 2,3,…, and slot sequence 0,1,2,3,4,0.
3. dly=4, cen toggled 1,0,1,0. Required: same drop values as scenario 2, with only cen edges counted and no change while cen=0.
4. After filling 5,6,7,8,9 with dly=4, set hold=1 and din=0x1F. Required: drop repeats 5,6,7,8,9 on two consecutive passes.
5. Change dly 4→2 at slot 2. Required: slot continues 3,4,0,1,2,0, so the new length applies only after the wrap.
6. Pulse clr at slot 3 while data is non-zero. Required: busy=1 for 32 cen edges, then all drops 0 and slot restarts at 0. With JT51_SLOT_DLY_PARITY_EN defined, a forced flip of one stored bit gives perr=1 on its read edge only.
